// File: rtl/ex_stage_fwd.sv
`default_nettype none
// ============================================================================
// Module   : ex_stage_fwd
// Brief    : Pipelined-CPU execute stage. Contains operand forwarding from
//            MEM/WB, the ALU, the branch-target adder, an iterative
//            multiply/divide unit with HI/LO, and the EX/MEM register with
//            stall/flush/valid handling.
// Revision : 1.0 - initial release
// ============================================================================
module ex_stage_fwd #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_valid,
    input  logic [DATA_W-1:0] i_next_pc,
    input  logic [DATA_W-1:0] i_read_data1,
    input  logic [DATA_W-1:0] i_read_data2,
    input  logic [DATA_W-1:0] i_imm,
    input  logic [REG_AW-1:0] i_rs,
    input  logic [REG_AW-1:0] i_rt,
    input  logic [REG_AW-1:0] i_rd,
    input  logic [1:0]        i_WB_control,
    input  logic [2:0]        i_MEM_control,
    input  logic [3:0]        i_EX_control,
    input  logic              i_mem_fwd_we,
    input  logic [REG_AW-1:0] i_mem_fwd_reg,
    input  logic [DATA_W-1:0] i_mem_fwd_data,
    input  logic              i_wb_fwd_we,
    input  logic [REG_AW-1:0] i_wb_fwd_reg,
    input  logic [DATA_W-1:0] i_wb_fwd_data,
    input  logic              i_stall_in,
    input  logic              i_flush,
    output logic              o_stall,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_branch_pc,
    output logic [DATA_W-1:0] o_result,
    output logic [DATA_W-1:0] o_read_data2,
    output logic              o_zero,
    output logic [REG_AW-1:0] o_write_reg,
    output logic [1:0]        o_WB_control,
    output logic [2:0]        o_MEM_control
);
    localparam int SH_W = $clog2(DATA_W);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_BUSY = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

    localparam logic [DATA_W-1:0] c_ZERO = '0;
    localparam logic [DATA_W-1:0] c_ONES = '1;

    // ------------------------------------------------------------------
    // Operand forwarding and ALU
    // ------------------------------------------------------------------
    logic [DATA_W-1:0]   w_fwd_a, w_fwd_b, w_alu_b, w_alu_res;
    logic [DATA_W-1:0]   w_hi_rd, w_lo_rd, w_new_hi, w_new_lo;
    logic [5:0]          w_funct;
    logic [SH_W-1:0]     w_shamt;
    logic                w_is_md, w_lt_s, w_lt_u;

    assign w_funct = i_imm[5:0];
    assign w_shamt = i_imm[6+SH_W-1:6];
    assign w_is_md = (i_EX_control[2:1] == 2'b10) && (w_funct[5:2] == 4'b0110);
    assign w_alu_b = i_EX_control[3] ? i_imm : w_fwd_b;
    assign w_lt_s  = $signed(w_fwd_a) < $signed(w_alu_b);
    assign w_lt_u  = w_fwd_a < w_alu_b;

    // Pick the youngest in-flight writer of rs/rt; register 0 is never forwarded
    always_comb begin
        w_fwd_a = i_read_data1;
        if (i_mem_fwd_we && (i_mem_fwd_reg == i_rs) && (i_mem_fwd_reg != '0))
            w_fwd_a = i_mem_fwd_data;
        else if (i_wb_fwd_we && (i_wb_fwd_reg == i_rs) && (i_wb_fwd_reg != '0))
            w_fwd_a = i_wb_fwd_data;
        w_fwd_b = i_read_data2;
        if (i_mem_fwd_we && (i_mem_fwd_reg == i_rt) && (i_mem_fwd_reg != '0))
            w_fwd_b = i_mem_fwd_data;
        else if (i_wb_fwd_we && (i_wb_fwd_reg == i_rt) && (i_wb_fwd_reg != '0))
            w_fwd_b = i_wb_fwd_data;
    end

    // ALUOp / funct decode; mul/div and unknown functs produce 0
    always_comb begin
        w_alu_res = c_ZERO;
        case (i_EX_control[2:1])
            2'b00: w_alu_res = w_fwd_a + w_alu_b;
            2'b01: w_alu_res = w_fwd_a - w_alu_b;
            2'b11: w_alu_res = {{(DATA_W-1){1'b0}}, w_lt_s};
            default: begin
                case (w_funct)
                    6'h20, 6'h21: w_alu_res = w_fwd_a + w_alu_b;
                    6'h22, 6'h23: w_alu_res = w_fwd_a - w_alu_b;
                    6'h24:        w_alu_res = w_fwd_a & w_alu_b;
                    6'h25:        w_alu_res = w_fwd_a | w_alu_b;
                    6'h26:        w_alu_res = w_fwd_a ^ w_alu_b;
                    6'h27:        w_alu_res = ~(w_fwd_a | w_alu_b);
                    6'h2A:        w_alu_res = {{(DATA_W-1){1'b0}}, w_lt_s};
                    6'h2B:        w_alu_res = {{(DATA_W-1){1'b0}}, w_lt_u};
                    6'h00:        w_alu_res = w_alu_b << w_shamt;
                    6'h02:        w_alu_res = w_alu_b >> w_shamt;
                    6'h03:        w_alu_res = $signed(w_alu_b) >>> w_shamt;
                    6'h10:        w_alu_res = w_hi_rd;
                    6'h12:        w_alu_res = w_lo_rd;
                    default:      w_alu_res = c_ZERO;
                endcase
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Iterative multiply / divide
    // ------------------------------------------------------------------
    logic [1:0]          r_state, w_state_nxt;
    logic [SH_W-1:0]     r_cnt;
    logic                r_md_div, r_neg_a, r_neg_b;
    logic [DATA_W-1:0]   r_mag_b, r_acc_hi, r_acc_lo, r_hi, r_lo;
    logic                w_accept, w_hilo_we, w_neg_a, w_neg_b;
    logic [DATA_W:0]     w_madd, w_rem_sh, w_trial;
    logic [2*DATA_W-1:0] w_prod, w_prod_fix;
    logic [DATA_W-1:0]   w_q_fix, w_rem_fix;

    assign w_accept  = (r_state == c_ST_IDLE) && i_valid && w_is_md && !i_flush && !i_rst;
    assign w_hilo_we = (r_state == c_ST_DONE) && !i_stall_in && !i_flush;
    assign w_neg_a   = !w_funct[0] && w_fwd_a[DATA_W-1];
    assign w_neg_b   = !w_funct[0] && w_fwd_b[DATA_W-1];

    assign w_madd   = {1'b0, r_acc_hi} + (r_acc_lo[0] ? {1'b0, r_mag_b} : {1'b0, c_ZERO});
    assign w_rem_sh = {r_acc_hi, r_acc_lo[DATA_W-1]};
    assign w_trial  = w_rem_sh - {1'b0, r_mag_b};

    // Sign fix-up applied on magnitudes: quotient/product by sign XOR, remainder by dividend
    assign w_prod     = {r_acc_hi, r_acc_lo};
    assign w_prod_fix = (r_neg_a ^ r_neg_b) ? (~w_prod + 1'b1) : w_prod;
    assign w_q_fix    = (r_neg_a ^ r_neg_b) ? (~r_acc_lo + 1'b1) : r_acc_lo;
    assign w_rem_fix  = r_neg_a ? (~r_acc_hi + 1'b1) : r_acc_hi;
    assign w_new_hi   = r_md_div ? w_rem_fix : w_prod_fix[2*DATA_W-1:DATA_W];
    assign w_new_lo   = r_md_div ? ((r_mag_b == c_ZERO) ? c_ONES : w_q_fix)
                                 : w_prod_fix[DATA_W-1:0];

    // MFHI/MFLO see a value retiring at this same edge
    assign w_hi_rd = w_hilo_we ? w_new_hi : r_hi;
    assign w_lo_rd = w_hilo_we ? w_new_lo : r_lo;

    assign o_stall = i_stall_in || w_accept || (r_state == c_ST_BUSY);

    // FSM state register
    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= c_ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    // FSM next state; flush aborts from any state
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: if (w_accept) w_state_nxt = c_ST_BUSY;
            c_ST_BUSY: if (r_cnt == '0) w_state_nxt = c_ST_DONE;
            c_ST_DONE: if (!i_stall_in) w_state_nxt = c_ST_IDLE;
            default:   w_state_nxt = c_ST_IDLE;
        endcase
        if (i_flush) w_state_nxt = c_ST_IDLE;
    end

    // Operand latch at acceptance, then one shift-add or restoring-subtract step per cycle
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt    <= '0;
            r_md_div <= 1'b0;
            r_neg_a  <= 1'b0;
            r_neg_b  <= 1'b0;
            r_mag_b  <= '0;
            r_acc_hi <= '0;
            r_acc_lo <= '0;
        end else if (w_accept) begin
            r_cnt    <= SH_W'(DATA_W - 1);
            r_md_div <= w_funct[1];
            r_neg_a  <= w_neg_a;
            r_neg_b  <= w_neg_b;
            r_mag_b  <= w_neg_b ? (~w_fwd_b + 1'b1) : w_fwd_b;
            r_acc_hi <= '0;
            r_acc_lo <= w_neg_a ? (~w_fwd_a + 1'b1) : w_fwd_a;
        end else if (r_state == c_ST_BUSY) begin
            r_cnt <= r_cnt - 1'b1;
            if (r_md_div) begin
                r_acc_hi <= w_trial[DATA_W] ? w_rem_sh[DATA_W-1:0] : w_trial[DATA_W-1:0];
                r_acc_lo <= {r_acc_lo[DATA_W-2:0], ~w_trial[DATA_W]};
            end else begin
                r_acc_hi <= w_madd[DATA_W:1];
                r_acc_lo <= {w_madd[0], r_acc_lo[DATA_W-1:1]};
            end
        end
    end

    // HI/LO written when a mul/div leaves DONE
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (w_hilo_we) begin
            r_hi <= w_new_hi;
            r_lo <= w_new_lo;
        end
    end

    // ------------------------------------------------------------------
    // EX/MEM pipeline register
    // ------------------------------------------------------------------
    logic              r_valid, r_zero;
    logic [DATA_W-1:0] r_branch_pc, r_result, r_read_data2;
    logic [REG_AW-1:0] r_write_reg;
    logic [1:0]        r_wb_ctl;
    logic [2:0]        r_mem_ctl;
    logic              w_retire;

    // A mul/div in flight sends bubbles until it retires from DONE
    assign w_retire = i_valid && !w_accept && (r_state != c_ST_BUSY);

    // Flush beats stall; stall holds the whole register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_valid      <= 1'b0;
            r_zero       <= 1'b0;
            r_branch_pc  <= '0;
            r_result     <= '0;
            r_read_data2 <= '0;
            r_write_reg  <= '0;
            r_wb_ctl     <= '0;
            r_mem_ctl    <= '0;
        end else if (i_flush) begin
            r_valid   <= 1'b0;
            r_wb_ctl  <= '0;
            r_mem_ctl <= '0;
        end else if (!i_stall_in) begin
            r_valid      <= w_retire;
            r_wb_ctl     <= w_retire ? i_WB_control : 2'b00;
            r_mem_ctl    <= w_retire ? i_MEM_control : 3'b000;
            r_zero       <= (w_alu_res == c_ZERO);
            r_result     <= w_alu_res;
            r_branch_pc  <= i_next_pc + (i_imm << 2);
            r_read_data2 <= w_fwd_b;
            r_write_reg  <= i_EX_control[0] ? i_rd : i_rt;
        end
    end

    assign o_valid       = r_valid;
    assign o_zero        = r_zero;
    assign o_branch_pc   = r_branch_pc;
    assign o_result      = r_result;
    assign o_read_data2  = r_read_data2;
    assign o_write_reg   = r_write_reg;
    assign o_WB_control  = r_wb_ctl;
    assign o_MEM_control = r_mem_ctl;

endmodule
`default_nettype wire

// File: tb/tb_ex_stage_fwd.sv
`default_nettype none
// ============================================================================
// Module   : tb_ex_stage_fwd
// Brief    : Scoreboard bench for ex_stage_fwd with directed vectors.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ex_stage_fwd;
    logic        clk = 1'b0;
    logic        rst;
    logic        i_valid;
    logic [31:0] i_next_pc, i_read_data1, i_read_data2, i_imm;
    logic [4:0]  i_rs, i_rt, i_rd;
    logic [1:0]  i_WB_control;
    logic [2:0]  i_MEM_control;
    logic [3:0]  i_EX_control;
    logic        i_mem_fwd_we, i_wb_fwd_we;
    logic [4:0]  i_mem_fwd_reg, i_wb_fwd_reg;
    logic [31:0] i_mem_fwd_data, i_wb_fwd_data;
    logic        i_stall_in, i_flush;
    logic        o_stall, o_valid, o_zero;
    logic [31:0] o_branch_pc, o_result, o_read_data2;
    logic [4:0]  o_write_reg;
    logic [1:0]  o_WB_control;
    logic [2:0]  o_MEM_control;

    always #5 clk = ~clk;

    ex_stage_fwd #(.DATA_W(32), .REG_AW(5)) dut (
        .i_clk(clk), .i_rst(rst), .i_valid(i_valid),
        .i_next_pc(i_next_pc), .i_read_data1(i_read_data1), .i_read_data2(i_read_data2),
        .i_imm(i_imm), .i_rs(i_rs), .i_rt(i_rt), .i_rd(i_rd),
        .i_WB_control(i_WB_control), .i_MEM_control(i_MEM_control), .i_EX_control(i_EX_control),
        .i_mem_fwd_we(i_mem_fwd_we), .i_mem_fwd_reg(i_mem_fwd_reg), .i_mem_fwd_data(i_mem_fwd_data),
        .i_wb_fwd_we(i_wb_fwd_we), .i_wb_fwd_reg(i_wb_fwd_reg), .i_wb_fwd_data(i_wb_fwd_data),
        .i_stall_in(i_stall_in), .i_flush(i_flush),
        .o_stall(o_stall), .o_valid(o_valid), .o_branch_pc(o_branch_pc), .o_result(o_result),
        .o_read_data2(o_read_data2), .o_zero(o_zero), .o_write_reg(o_write_reg),
        .o_WB_control(o_WB_control), .o_MEM_control(o_MEM_control)
    );

    typedef struct {
        logic [31:0] result;
        logic        zero;
        logic [4:0]  wreg;
        logic        chk_x;
        logic [31:0] rd2;
        logic [31:0] br;
    } exp_t;

    exp_t q[$];
    exp_t m_e;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   md_cnt;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic [31:0] npc, input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] imm, input logic [4:0] rs, input logic [4:0] rt,
                             input logic [4:0] rd, input logic [3:0] exc);
        i_valid = 1'b1; i_next_pc = npc; i_read_data1 = a; i_read_data2 = b; i_imm = imm;
        i_rs = rs; i_rt = rt; i_rd = rd; i_EX_control = exc;
        i_WB_control = 2'b10; i_MEM_control = 3'b101;
    endtask

    // R-type: ALUSrc=0, ALUOp=10, RegDst=1; funct and shamt ride in imm
    task automatic rtype(input logic [31:0] a, input logic [31:0] b, input logic [5:0] fn,
                         input logic [4:0] sh, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd);
        set_instr(32'h0, a, b, {21'h0, sh, fn}, rs, rt, rd, 4'b0101);
    endtask

    task automatic expect_ret(input logic [31:0] res, input logic z, input logic [4:0] wreg,
                              input logic cx, input logic [31:0] rd2, input logic [31:0] br);
        exp_t e;
        e.result = res; e.zero = z; e.wreg = wreg; e.chk_x = cx; e.rd2 = rd2; e.br = br;
        q.push_back(e);
    endtask

    // Counts stall cycles of a mul/div; returns at the DONE-cycle negedge
    task automatic run_md(output int cnt);
        cnt = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (!o_stall) break;
            cnt++;
        end
    endtask

    // Monitor: every retirement is matched against the oldest expectation
    always @(negedge clk) begin
        if (!rst && o_valid) begin
            if (q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_retire actual=%h required=none", o_result);
            end else begin
                m_e = q.pop_front();
                chk("result", o_result, m_e.result);
                chk("zero", {31'h0, o_zero}, {31'h0, m_e.zero});
                chk("write_reg", {27'h0, o_write_reg}, {27'h0, m_e.wreg});
                chk("wb_ctl", {30'h0, o_WB_control}, 32'h2);
                chk("mem_ctl", {29'h0, o_MEM_control}, 32'h5);
                if (m_e.chk_x) begin
                    chk("read_data2", o_read_data2, m_e.rd2);
                    chk("branch_pc", o_branch_pc, m_e.br);
                end
            end
        end
    end

    initial begin
        rst = 1'b1; i_valid = 1'b0; i_next_pc = '0; i_read_data1 = '0; i_read_data2 = '0;
        i_imm = '0; i_rs = '0; i_rt = '0; i_rd = '0; i_WB_control = '0; i_MEM_control = '0;
        i_EX_control = '0; i_mem_fwd_we = 1'b0; i_mem_fwd_reg = '0; i_mem_fwd_data = '0;
        i_wb_fwd_we = 1'b0; i_wb_fwd_reg = '0; i_wb_fwd_data = '0;
        i_stall_in = 1'b0; i_flush = 1'b0;
        repeat (2) step();
        @(negedge clk);
        chk("rst_valid", {31'h0, o_valid}, 32'h0);
        chk("rst_result", o_result, 32'h0);
        chk("rst_stall", {31'h0, o_stall}, 32'h0);
        chk("rst_wb_ctl", {30'h0, o_WB_control}, 32'h0);
        step();
        rst = 1'b0;

        // Forwarding: MEM beats WB
        i_mem_fwd_we = 1'b1; i_mem_fwd_reg = 5'd3; i_mem_fwd_data = 32'h11;
        i_wb_fwd_we  = 1'b1; i_wb_fwd_reg  = 5'd3; i_wb_fwd_data  = 32'h22;
        rtype(32'h5, 32'h5, 6'h20, 5'd0, 5'd3, 5'd3, 5'd8);
        expect_ret(32'h22, 1'b0, 5'd8, 1'b1, 32'h11, 32'h80);
        step();
        // Register 0 is never forwarded
        i_mem_fwd_reg = 5'd0; i_wb_fwd_reg = 5'd0;
        rtype(32'h5, 32'h5, 6'h20, 5'd0, 5'd0, 5'd0, 5'd9);
        expect_ret(32'hA, 1'b0, 5'd9, 1'b1, 32'h5, 32'h80);
        step();
        // WB source when MEM targets another register
        i_mem_fwd_reg = 5'd4; i_wb_fwd_reg = 5'd3;
        rtype(32'h5, 32'h5, 6'h20, 5'd0, 5'd3, 5'd3, 5'd10);
        expect_ret(32'h44, 1'b0, 5'd10, 1'b1, 32'h22, 32'h80);
        step();
        i_mem_fwd_we = 1'b0; i_wb_fwd_we = 1'b0;

        // ALU vectors
        rtype(32'hFFFFFFFF, 32'h1, 6'h20, 5'd0, 5'd1, 5'd2, 5'd11);
        expect_ret(32'h0, 1'b1, 5'd11, 1'b0, 32'h0, 32'h0);
        step();
        rtype(32'hFFFFFFFF, 32'h1, 6'h2A, 5'd0, 5'd1, 5'd2, 5'd12);
        expect_ret(32'h1, 1'b0, 5'd12, 1'b0, 32'h0, 32'h0);
        step();
        rtype(32'hFFFFFFFF, 32'h1, 6'h2B, 5'd0, 5'd1, 5'd2, 5'd13);
        expect_ret(32'h0, 1'b1, 5'd13, 1'b0, 32'h0, 32'h0);
        step();
        rtype(32'h0, 32'h80000000, 6'h03, 5'd4, 5'd1, 5'd2, 5'd14);
        expect_ret(32'hF8000000, 1'b0, 5'd14, 1'b0, 32'h0, 32'h0);
        step();
        rtype(32'h0F0F0000, 32'h000000FF, 6'h27, 5'd0, 5'd1, 5'd2, 5'd15);
        expect_ret(32'hF0F0FF00, 1'b0, 5'd15, 1'b0, 32'h0, 32'h0);
        step();
        rtype(32'h12345678, 32'h1, 6'h3F, 5'd0, 5'd1, 5'd2, 5'd16);
        expect_ret(32'h0, 1'b1, 5'd16, 1'b0, 32'h0, 32'h0);
        step();
        // Branch: SUB compare, RegDst=0, target = 0x100 + (-2<<2)
        set_instr(32'h100, 32'h5, 32'h5, 32'hFFFFFFFE, 5'd1, 5'd2, 5'd7, 4'b0010);
        expect_ret(32'h0, 1'b1, 5'd2, 1'b1, 32'h5, 32'hF8);
        step();
        // Immediate add: ALUSrc=1, ALUOp=00, RegDst=0
        set_instr(32'h0, 32'h10, 32'h99, 32'h5, 5'd1, 5'd6, 5'd7, 4'b1000);
        expect_ret(32'h15, 1'b0, 5'd6, 1'b1, 32'h99, 32'h14);
        step();
        i_valid = 1'b0;
        step();

        // MULT -3 x 7
        rtype(32'hFFFFFFFD, 32'h7, 6'h18, 5'd0, 5'd1, 5'd2, 5'd17);
        expect_ret(32'h0, 1'b1, 5'd17, 1'b0, 32'h0, 32'h0);
        run_md(md_cnt);
        chk("mult_stall_cycles", md_cnt, 32'd33);
        step();
        rtype(32'h0, 32'h0, 6'h12, 5'd0, 5'd0, 5'd0, 5'd18);
        expect_ret(32'hFFFFFFEB, 1'b0, 5'd18, 1'b0, 32'h0, 32'h0);
        step();
        rtype(32'h0, 32'h0, 6'h10, 5'd0, 5'd0, 5'd0, 5'd19);
        expect_ret(32'hFFFFFFFF, 1'b0, 5'd19, 1'b0, 32'h0, 32'h0);
        step();

        // DIV 7 / -2
        rtype(32'h7, 32'hFFFFFFFE, 6'h1A, 5'd0, 5'd1, 5'd2, 5'd20);
        expect_ret(32'h0, 1'b1, 5'd20, 1'b0, 32'h0, 32'h0);
        run_md(md_cnt);
        chk("div_stall_cycles", md_cnt, 32'd33);
        step();
        rtype(32'h0, 32'h0, 6'h12, 5'd0, 5'd0, 5'd0, 5'd21);
        expect_ret(32'hFFFFFFFD, 1'b0, 5'd21, 1'b0, 32'h0, 32'h0);
        step();
        rtype(32'h0, 32'h0, 6'h10, 5'd0, 5'd0, 5'd0, 5'd22);
        expect_ret(32'h1, 1'b0, 5'd22, 1'b0, 32'h0, 32'h0);
        step();

        // DIVU 5 / 0
        rtype(32'h5, 32'h0, 6'h1B, 5'd0, 5'd1, 5'd2, 5'd23);
        expect_ret(32'h0, 1'b1, 5'd23, 1'b0, 32'h0, 32'h0);
        run_md(md_cnt);
        step();
        rtype(32'h0, 32'h0, 6'h12, 5'd0, 5'd0, 5'd0, 5'd24);
        expect_ret(32'hFFFFFFFF, 1'b0, 5'd24, 1'b0, 32'h0, 32'h0);
        step();
        rtype(32'h0, 32'h0, 6'h10, 5'd0, 5'd0, 5'd0, 5'd25);
        expect_ret(32'h5, 1'b0, 5'd25, 1'b0, 32'h0, 32'h0);
        step();

        // Flush at BUSY cycle 10: no retirement, HI/LO kept, FSM back to IDLE
        rtype(32'h3, 32'h3, 6'h19, 5'd0, 5'd1, 5'd2, 5'd26);
        repeat (10) step();
        i_flush = 1'b1;
        step();
        i_flush = 1'b0;
        rtype(32'h0, 32'h0, 6'h12, 5'd0, 5'd0, 5'd0, 5'd27);
        expect_ret(32'hFFFFFFFF, 1'b0, 5'd27, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        chk("flush_valid", {31'h0, o_valid}, 32'h0);
        chk("flush_fsm_idle_stall", {31'h0, o_stall}, 32'h0);
        step();
        rtype(32'h0, 32'h0, 6'h10, 5'd0, 5'd0, 5'd0, 5'd28);
        expect_ret(32'h5, 1'b0, 5'd28, 1'b0, 32'h0, 32'h0);
        step();

        // Downstream stall held for 3 cycles in DONE delays retirement
        rtype(32'h2, 32'h3, 6'h19, 5'd0, 5'd1, 5'd2, 5'd29);
        expect_ret(32'h0, 1'b1, 5'd29, 1'b0, 32'h0, 32'h0);
        run_md(md_cnt);
        i_stall_in = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("stall_hold_valid", {31'h0, o_valid}, 32'h0);
            chk("stall_hold_stall", {31'h0, o_stall}, 32'h1);
        end
        i_stall_in = 1'b0;
        step();
        chk("stall_retire_valid", {31'h0, o_valid}, 32'h1);
        rtype(32'h0, 32'h0, 6'h12, 5'd0, 5'd0, 5'd0, 5'd30);
        expect_ret(32'h6, 1'b0, 5'd30, 1'b0, 32'h0, 32'h0);
        step();

        // Reset in the middle of a multiply
        rtype(32'hFFFFFFFD, 32'h7, 6'h18, 5'd0, 5'd1, 5'd2, 5'd31);
        repeat (5) step();
        rst = 1'b1;
        step();
        chk("midrst_valid", {31'h0, o_valid}, 32'h0);
        chk("midrst_stall", {31'h0, o_stall}, 32'h0);
        chk("midrst_write_reg", {27'h0, o_write_reg}, 32'h0);
        chk("midrst_branch_pc", o_branch_pc, 32'h0);
        chk("midrst_read_data2", o_read_data2, 32'h0);
        rst = 1'b0;
        rtype(32'h0, 32'h0, 6'h12, 5'd0, 5'd0, 5'd0, 5'd5);
        expect_ret(32'h0, 1'b1, 5'd5, 1'b0, 32'h0, 32'h0);
        step();
        rtype(32'h0, 32'h0, 6'h10, 5'd0, 5'd0, 5'd0, 5'd6);
        expect_ret(32'h0, 1'b1, 5'd6, 1'b0, 32'h0, 32'h0);
        step();
        i_valid = 1'b0;
        repeat (3) step();
        chk("scoreboard_drained", q.size(), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ex_stage_fwd.md
# ex_stage_fwd

Parametrised execute stage for the pipelined CPU: ALU, branch-target adder, RegDst/ALUSrc selection and EX/MEM pipeline register. It also adds operand forwarding from MEM and WB, an iterative multiply/divide unit with HI/LO registers, and stall/flush/valid handshaking. It sits between the ID/EX register and the MEM stage, and drives a stall back to the hazard unit while a multiply/divide is in flight.

## Interface
- DATA_W, 32, datapath width (power of 2, ≥8); SH_W = clog2(DATA_W) shift-amount bits
- REG_AW, 5, register-address width
- i_clk  in  1  clock, all state on rising edge
- i_rst  in  1  synchronous, active-high reset
- i_valid  in  1  EX input holds a real instruction
- i_next_pc, i_read_data1, i_read_data2, i_imm  in  DATA_W  PC+4, rs/rt register-file data, sign-extended immediate
- i_rs, i_rt, i_rd  in  REG_AW  source/target/destination register numbers
- i_WB_control  in  2  [1]=RegWrite, [0]=MemtoReg; passed through
- i_MEM_control  in  3  passed through
- i_EX_control  in  4  [3]=ALUSrc (1=imm), [2:1]=ALUOp, [0]=RegDst (1=rd)
- i_mem_fwd_we, i_mem_fwd_reg, i_mem_fwd_data  in  1/REG_AW/DATA_W  EX/MEM write-back candidate
- i_wb_fwd_we, i_wb_fwd_reg, i_wb_fwd_data  in  1/REG_AW/DATA_W  MEM/WB write-back candidate
- i_stall_in  in  1  downstream hold
- i_flush  in  1  kill EX contents
- o_stall  out  1  upstream must hold ID/EX
- o_valid  out  1  EX/MEM holds a real instruction
- o_branch_pc, o_result, o_read_data2  out  DATA_W  registered branch target, ALU result, forwarded rt
- o_zero  out  1  registered (ALU result == 0)
- o_write_reg  out  REG_AW  registered RegDst-selected destination register
- o_WB_control, o_MEM_control  out  2/3  registered, zeroed when o_valid=0

## Operation
- Forwarding, applied per operand A (rs) and B (rt):
  - MEM source when i_mem_fwd_we and reg match and reg≠0.
  - Otherwise WB source under the same rule.
  - Otherwise register-file data.
- ALU input B = ALUSrc ? i_imm : forwarded rt. o_read_data2 = forwarded rt.
- ALUOp decode:
  - 00 → ADD; 01 → SUB; 11 → SLT (signed).
  - 10 → funct i_imm[5:0]: 0x20/0x21 ADD, 0x22/0x23 SUB, 0x24 AND, 0x25 OR, 0x26 XOR, 0x27 NOR, 0x2A SLT, 0x2B SLTU.
  - funct 0x00 SLL, 0x02 SRL, 0x03 SRA of B by shamt = i_imm[6+SH_W-1:6].
  - funct 0x10 MFHI, 0x12 MFLO.
  - funct 0x18 MULT, 0x19 MULTU, 0x1A DIV, 0x1B DIVU.
  - Undefined funct → result 0.
- Arithmetic is modulo 2^DATA_W with no overflow trap. Branch target = i_next_pc + (i_imm << 2), truncated to DATA_W.
- Mul/div FSM states:
  - IDLE → BUSY on accepting a valid mul/div; latch operand magnitudes and signs.
  - BUSY: one shift-add (mult) or restoring-subtract (div) step per cycle; counter runs DATA_W−1 … 0.
  - BUSY → DONE when the counter reaches 0.
  - DONE: apply sign fix-up, write HI/LO, go to IDLE. MULT: {HI,LO} = 2·DATA_W-bit product. DIV: LO = quotient, HI = remainder (remainder takes the dividend's sign).
- Divide by zero: LO = all ones, HI = dividend; no exception.
- MFHI/MFLO read HI/LO as they stand, including a value written at the same edge the mul/div retires (HI/LO bypass).

## Timing
- Reset: all outputs 0, HI = LO = 0, FSM IDLE, o_stall = 0.
- ALU/branch instruction: 1-cycle latency; the result appears in EX/MEM at the next edge.
- Mul/div:
  - o_stall = 1 combinationally from the acceptance cycle through BUSY; it drops in DONE.
  - EX/MEM receives bubbles (o_valid = 0, controls zeroed) while BUSY.
  - The instruction retires to EX/MEM at the DONE edge with o_result = 0.
  - Total occupancy is DATA_W+2 cycles.
- i_stall_in = 1:
  - EX/MEM holds its value and o_stall = 1.
  - The mul/div counter keeps running; DONE waits in place until i_stall_in = 0.
- i_flush = 1: on the next edge o_valid = 0, the FSM aborts to IDLE, and HI/LO are unchanged. Flush has priority over stall and over DONE.
- i_valid = 0: o_valid = 0 next edge and no mul/div start.
- Reset mid-operation: identical to the reset state; the partial product is discarded.

## Test plan
- Forwarding: MEM fwd (r3 = 0x11), WB fwd (r3 = 0x22), ADD r3,r3 → o_result = 0x22 (MEM wins). Repeat with reg 0 → the register-file value is used.
- ALU: 0xFFFFFFFF + 1 → o_result = 0, o_zero = 1. SLT −1,1 → 1. SLTU −1,1 → 0. SRA 0x80000000 by 4 → 0xF8000000.
- Branch: i_next_pc = 0x100, i_imm = −2 → o_branch_pc = 0xF8.
- MULT −3×7: o_stall high for 33 cycles. Then MFLO → 0xFFFFFFEB, MFHI → 0xFFFFFFFF. DIV 7/−2 → LO = 0xFFFFFFFD, HI = 1.
- DIVU 5/0 → LO = 0xFFFFFFFF, HI = 5.
- Control: flush at BUSY cycle 10 → HI/LO unchanged and FSM IDLE. i_stall_in held for 3 cycles during DONE → retirement is delayed 3 cycles. i_rst asserted mid-mult → all outputs 0 next edge.
